mux2_3: RTL and testbench

- Two-input, word-wide selector with a registered output stage.
- Controle picks Entrada0 (Controle=0) or Entrada1 (Controle=1).
- The chosen word appears on Resultado one clock after sampling.
- Used as a datapath source selector in the 8-bit processor, feeding register-file and ALU operand paths.

---
 rtl/mux2_3_pkg.sv | 13 +
 rtl/registrador_async.sv | 22 ++
 rtl/mux2_3.sv | 44 ++++
 tb/tb_mux2_3.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mux2_3_pkg.sv
// Shared constants for the processor datapath selectors: default word width,
// the reset value and the meaning of the select line.
package mux2_3_pkg;

  localparam int          LARGURA_PADRAO = 4;
  localparam logic [31:0] ZERO           = 32'h0000_0000;

  typedef enum logic {
    SEL_ENTRADA0 = 1'b0,
    SEL_ENTRADA1 = 1'b1
  } controle_t;

endpackage

// File: rtl/registrador_async.sv
// LARGURA-wide D flip-flop bank with asynchronous active-high reset to a
// configurable reset value.
module registrador_async #(
  parameter int                 LARGURA     = 4,
  parameter logic [LARGURA-1:0] VALOR_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  // Reset takes effect without a clock and wins over a coincident edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= VALOR_RESET;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux2_3.sv
// Two-input word selector for the datapath operand paths; the output is
// either registered (1-cycle latency) or purely combinational.
module mux2_3
  import mux2_3_pkg::*;
#(
  parameter int          LARGURA     = LARGURA_PADRAO,
  parameter int          REGISTRADO  = 1,
  parameter logic [31:0] VALOR_RESET = ZERO
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LARGURA-1:0] Entrada0,
  input  logic [LARGURA-1:0] Entrada1,
  input  logic               Controle,
  output logic [LARGURA-1:0] Resultado
);

  logic [LARGURA-1:0] sel;

  always_comb begin
    sel = Entrada0;
    if (controle_t'(Controle) == SEL_ENTRADA1) begin
      sel = Entrada1;
    end
  end

  // In the combinational variant Clock and Reset are intentionally left unused.
  generate
    if (REGISTRADO != 0) begin : g_reg
      registrador_async #(
        .LARGURA    (LARGURA),
        .VALOR_RESET(VALOR_RESET[LARGURA-1:0])
      ) u_reg (
        .clk(Clock),
        .rst(Reset),
        .d  (sel),
        .q  (Resultado)
      );
    end else begin : g_comb
      assign Resultado = sel;
    end
  endgenerate

endmodule

// File: tb/tb_mux2_3.sv
// Directed bench for mux2_3: registered default build, a registered build with
// a truncated non-zero reset value, and an 8-bit combinational build.
module tb_mux2_3;

  logic       clock;
  logic       reset;
  logic [3:0] entrada0;
  logic [3:0] entrada1;
  logic       controle;
  logic [3:0] resultado;
  logic [3:0] resultadoRv;

  logic [7:0] entradaC0;
  logic [7:0] entradaC1;
  logic       controleC;
  logic [7:0] resultadoC;

  int checkCount = 0;
  int passCount  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mux2_3 dut (
    .Clock    (clock),
    .Reset    (reset),
    .Entrada0 (entrada0),
    .Entrada1 (entrada1),
    .Controle (controle),
    .Resultado(resultado)
  );

  // 32'h1A truncated to 4 bits must give 4'hA.
  mux2_3 #(.LARGURA(4), .REGISTRADO(1), .VALOR_RESET(32'h0000_001A)) dutRv (
    .Clock    (clock),
    .Reset    (reset),
    .Entrada0 (entrada0),
    .Entrada1 (entrada1),
    .Controle (controle),
    .Resultado(resultadoRv)
  );

  mux2_3 #(.LARGURA(8), .REGISTRADO(0)) dutComb (
    .Clock    (clock),
    .Reset    (reset),
    .Entrada0 (entradaC0),
    .Entrada1 (entradaC1),
    .Controle (controleC),
    .Resultado(resultadoC)
  );

  task automatic test_reset;
    reset    = 1'b1;
    entrada0 = 4'b0111;
    entrada1 = 4'b0000;
    controle = 1'b0;
    #2;
    checkCount++;
    if (resultado !== 4'b0000)
      $display("[TB] FAIL reset_no_clock: got %b expected %b", resultado, 4'b0000);
    else passCount++;
    checkCount++;
    if (resultadoRv !== 4'hA)
      $display("[TB] FAIL reset_value_trunc: got %h expected %h", resultadoRv, 4'hA);
    else passCount++;
    // Reset high across a rising edge must keep the reset value.
    @(posedge clock); #1;
    checkCount++;
    if (resultado !== 4'b0000)
      $display("[TB] FAIL reset_on_edge: got %b expected %b", resultado, 4'b0000);
    else passCount++;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    checkCount++;
    if (resultado !== 4'b0111)
      $display("[TB] FAIL reset_release: got %b expected %b", resultado, 4'b0111);
    else passCount++;
    checkCount++;
    if (resultadoRv !== 4'b0111)
      $display("[TB] FAIL reset_release_rv: got %b expected %b", resultadoRv, 4'b0111);
    else passCount++;
  endtask

  task automatic test_select0;
    @(negedge clock);
    entrada1 = 4'b1010;
    controle = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    entrada0 = 4'b0111;
    entrada1 = 4'b0000;
    controle = 1'b0;
    @(posedge clock); #1;
    checkCount++;
    if (resultado !== 4'b0111)
      $display("[TB] FAIL select0: got %b expected %b", resultado, 4'b0111);
    else passCount++;
  endtask

  task automatic test_select1;
    @(negedge clock);
    controle = 1'b1;
    // Before the edge the output must still show the previous selection.
    #1;
    checkCount++;
    if (resultado !== 4'b0111)
      $display("[TB] FAIL hold_between_edges: got %b expected %b", resultado, 4'b0111);
    else passCount++;
    @(posedge clock); #1;
    checkCount++;
    if (resultado !== 4'b0000)
      $display("[TB] FAIL select1: got %b expected %b", resultado, 4'b0000);
    else passCount++;
  endtask

  task automatic test_toggle;
    logic [3:0] expected [4];
    expected[0] = 4'b0111;
    expected[1] = 4'b0000;
    expected[2] = 4'b0111;
    expected[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      controle = (i % 2 == 1);
      @(posedge clock); #1;
      checkCount++;
      if (resultado !== expected[i])
        $display("[TB] FAIL toggle_%0d: got %b expected %b", i, resultado, expected[i]);
      else passCount++;
    end
  endtask

  task automatic test_midrun_reset;
    @(negedge clock);
    controle = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkCount++;
    if (resultado !== 4'b0000)
      $display("[TB] FAIL midrun_reset_async: got %b expected %b", resultado, 4'b0000);
    else passCount++;
    @(posedge clock); #1;
    checkCount++;
    if (resultado !== 4'b0000)
      $display("[TB] FAIL midrun_reset_hold: got %b expected %b", resultado, 4'b0000);
    else passCount++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkCount++;
    if (resultado !== 4'b0000)
      $display("[TB] FAIL midrun_release_no_edge: got %b expected %b", resultado, 4'b0000);
    else passCount++;
    @(posedge clock); #1;
    checkCount++;
    if (resultado !== 4'b0111)
      $display("[TB] FAIL midrun_first_edge: got %b expected %b", resultado, 4'b0111);
    else passCount++;
  endtask

  task automatic test_combinational;
    logic [7:0] expected;
    entradaC0 = 8'hA5;
    entradaC1 = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      controleC = (i % 2 == 1);
      // Reset asserted for the second half shows it has no effect here.
      reset     = (i >= 2);
      expected  = (i % 2 == 1) ? 8'h3C : 8'hA5;
      #1;
      checkCount++;
      if (resultadoC !== expected)
        $display("[TB] FAIL comb_%0d: got %h expected %h", i, resultadoC, expected);
      else passCount++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    entrada0  = 4'b0000;
    entrada1  = 4'b0000;
    controle  = 1'b0;
    entradaC0 = 8'h00;
    entradaC1 = 8'h00;
    controleC = 1'b0;
    test_reset();
    test_select0();
    test_select1();
    test_toggle();
    test_midrun_reset();
    test_combinational();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
